// File: rtl/fp_pack_pkg.sv
// Shared constants for the IEEE-754 pack/unpack stages: format widths,
// exponent limits, class-flag indices and the operand class used by fp_pack.
package fp_pack_pkg;

  localparam int NEXP = 5;
  localparam int NSIG = 10;
  localparam int W    = 2*NSIG + 2;
  localparam int EW   = NEXP + 3;
  localparam int FW   = NEXP + NSIG + 1;

  localparam int BIAS_INT = (1 << (NEXP-1)) - 1;
  localparam logic signed [EW-1:0] BIAS = EW'(BIAS_INT);
  localparam logic signed [EW-1:0] EMIN = EW'(1 - BIAS_INT);
  localparam logic signed [EW-1:0] EMAX = EW'(BIAS_INT);

  localparam int FLAG_SNAN      = 0;
  localparam int FLAG_QNAN      = 1;
  localparam int FLAG_INFINITY  = 2;
  localparam int FLAG_ZERO      = 3;
  localparam int FLAG_SUBNORMAL = 4;
  localparam int FLAG_NORMAL    = 5;
  localparam int LAST_FLAG      = 6;

  typedef enum logic [1:0] {CLS_FINITE, CLS_NAN, CLS_INF, CLS_ZERO} valClass_t;

  function automatic valClass_t classify(input logic isNan, input logic isInf,
                                         input logic isZero);
    if (isNan)       return CLS_NAN;
    else if (isInf)  return CLS_INF;
    else if (isZero) return CLS_ZERO;
    return CLS_FINITE;
  endfunction

endpackage

// File: rtl/fp_pack_round_rne.sv
// Round-to-nearest-even of an (NSIG+1)-bit kept significand given guard and
// tail bits; a carry-out is already folded back into a normalized result.
module fp_round_rne
  import fp_pack_pkg::*;
(
  input  logic [NSIG:0] keep,
  input  logic          guard,
  input  logic          tail,
  output logic [NSIG:0] rounded,
  output logic          carry,
  output logic          inexact
);

  logic            roundUp;
  logic [NSIG+1:0] sum;

  always_comb begin
    roundUp = guard & (tail | keep[0]);
    sum     = {1'b0, keep} + (NSIG+2)'(roundUp);
    carry   = sum[NSIG+1];
    rounded = carry ? sum[NSIG+1:1] : sum[NSIG:0];
    inexact = guard | tail;
  end

endmodule

// File: rtl/fp_pack.sv
// Packs sign / unbiased exponent / wide significand into an IEEE-754 encoding
// with RNE rounding; normalization walks one bit per cycle.
module fp_pack
  import fp_pack_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic signed [EW-1:0]  in_exp,
  input  logic [W-1:0]          in_sig,
  input  logic [LAST_FLAG-1:0]  in_flags,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FW-1:0]         out_f,
  output logic                  out_ovf,
  output logic                  out_unf,
  output logic                  out_inexact
);

  // Specials skip NORM/DENORM and are encoded in ROUND, one cycle after accept.
  typedef enum logic [2:0] {IDLE, NORM, DENORM, ROUND, DONE} state_t;

  state_t                 state, stateNext;
  logic                   sign, st;
  logic signed [EW-1:0]   e, eRnd;
  logic [W-1:0]           s;
  valClass_t              cls, inClass;
  logic [FW-1:0]          outF, finiteF;
  logic                   ovf, unf, inexact;
  logic                   needRight, canLeft, belowMin;
  logic [NSIG:0]          rounded;
  logic                   carry, rndInexact, finOvf, finUnf;
  logic [NEXP-1:0]        biasedExp;
  logic                   unusedFlags;

  assign unusedFlags = ^in_flags[FLAG_NORMAL:FLAG_SUBNORMAL];
  assign inClass   = classify(in_flags[FLAG_SNAN] | in_flags[FLAG_QNAN],
                              in_flags[FLAG_INFINITY],
                              in_flags[FLAG_ZERO] || (in_sig == '0));
  assign needRight = s[W-1];
  assign canLeft   = !s[2*NSIG] && (e > EMIN);
  assign belowMin  = e < EMIN;

  fp_round_rne uRound (
    .keep    (s[2*NSIG:NSIG]),
    .guard   (s[NSIG-1]),
    .tail    ((|s[NSIG-2:0]) | st),
    .rounded (rounded),
    .carry   (carry),
    .inexact (rndInexact)
  );

  always_comb begin
    eRnd      = e + EW'(carry);
    biasedExp = NEXP'(eRnd + BIAS);
    finOvf    = 1'b0;
    finUnf    = 1'b0;
    if (eRnd > EMAX) begin
      finiteF = {sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
      finOvf  = 1'b1;
    end else if (!rounded[NSIG]) begin
      finiteF = {sign, {NEXP{1'b0}}, rounded[NSIG-1:0]};
      finUnf  = rndInexact;
    end else begin
      finiteF = {sign, biasedExp, rounded[NSIG-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (in_valid) stateNext = (inClass == CLS_FINITE) ? NORM : ROUND;
      NORM:    if (!needRight && !canLeft) stateNext = DENORM;
      DENORM:  if (!belowMin) stateNext = ROUND;
      ROUND:   stateNext = DONE;
      DONE:    if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state == IDLE);
    out_valid   = (state == DONE);
    out_f       = outF;
    out_ovf     = ovf;
    out_unf     = unf;
    out_inexact = inexact;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign    <= 1'b0;
      e       <= '0;
      s       <= '0;
      st      <= 1'b0;
      cls     <= CLS_FINITE;
      outF    <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      inexact <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          sign <= in_sign;
          e    <= in_exp;
          s    <= in_sig;
          st   <= 1'b0;
          cls  <= inClass;
        end
        NORM: if (needRight) begin
          s  <= s >> 1;
          st <= st | s[0];
          e  <= e + EW'(1);
        end else if (canLeft) begin
          s  <= s << 1;
          e  <= e - EW'(1);
        end
        DENORM: if (belowMin) begin
          if (s != '0) begin
            s  <= s >> 1;
            st <= st | s[0];
            e  <= e + EW'(1);
          end else begin
            e  <= EMIN;
          end
        end
        ROUND: begin
          ovf     <= 1'b0;
          unf     <= 1'b0;
          inexact <= 1'b0;
          unique case (cls)
            CLS_NAN:  outF <= {sign, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
            CLS_INF:  outF <= {sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
            CLS_ZERO: outF <= {sign, {(FW-1){1'b0}}};
            default: begin
              outF    <= finiteF;
              ovf     <= finOvf;
              unf     <= finUnf;
              inexact <= rndInexact | finOvf;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_pack.sv
// Bench for fp_pack: directed table, hold/reset sequences, and random
// operands checked against an arithmetic RNE reference model.
module tb_fp_pack;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_sign = 1'b0;
  logic signed [7:0] in_exp = '0;
  logic [21:0]       in_sig = '0;
  logic [5:0]        in_flags = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [15:0]       out_f;
  logic              out_ovf, out_unf, out_inexact;

  int nChecks = 0;
  int nErr = 0;

  localparam logic [5:0] SN  = 6'b000001;
  localparam logic [5:0] QN  = 6'b000010;
  localparam logic [5:0] INF = 6'b000100;
  localparam logic [5:0] ZR  = 6'b001000;
  localparam logic [5:0] NRM = 6'b100000;

  fp_pack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_sig(in_sig), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
    .out_ovf(out_ovf), .out_unf(out_unf), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sg;
    int          ex;
    logic [21:0] sig;
    logic [5:0]  fl;
    logic [15:0] f;
    logic        o, u, i;
    int          lat;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Exact value is sig * 2^(ex-20); quantize to the format's ulp at that magnitude.
  function automatic void model(input logic sgn, input int ex, input logic [21:0] sig,
                                input logic [5:0] fl, output logic [15:0] f,
                                output logic ovf, output logic unf, output logic inx);
    int p, bigE, q, k, m;
    logic g, t;
    ovf = 0; unf = 0; inx = 0;
    if (fl[0] | fl[1]) begin f = {sgn, 5'h1F, 1'b1, 9'h0}; return; end
    if (fl[2]) begin f = {sgn, 5'h1F, 10'h0}; return; end
    if (fl[3] || sig == 0) begin f = {sgn, 15'h0}; return; end
    p = 0;
    for (int i = 0; i < 22; i++) if (sig[i]) p = i;
    bigE = ex + p - 20;
    q = ((bigE > -14) ? bigE : -14) - 10;
    k = q - (ex - 20);
    m = 0; g = 0; t = 0;
    if (k <= 0) m = int'(sig) << (-k);
    else
      for (int i = 0; i < 22; i++)
        if (sig[i]) begin
          if (i >= k) m += (1 << (i - k));
          else if (i == k - 1) g = 1;
          else t = 1;
        end
    if (g && (t || (m & 1) != 0)) m++;
    if (m == 2048) begin m = 1024; q++; end
    inx = g | t;
    if (m >= 1024) begin
      if (q + 10 > 15) begin f = {sgn, 5'h1F, 10'h0}; ovf = 1; inx = 1; end
      else f = {sgn, 5'(q + 25), 10'(m - 1024)};
    end else begin
      f = {sgn, 5'h0, 10'(m)};
      unf = inx;
    end
  endfunction

  task automatic runOp(input string tag, input logic sg, input int ex, input logic [21:0] sig,
                       input logic [5:0] fl, input logic [15:0] eF, input logic eO,
                       input logic eU, input logic eI, input int eLat, input int hold);
    int lat;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_sign = sg; in_exp = 8'(ex); in_sig = sig; in_flags = fl; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      check({tag, " timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    if (eLat >= 0) check({tag, " latency"}, 32'(lat), 32'(eLat));
    check({tag, " out_f"}, 32'(out_f), 32'(eF));
    check({tag, " ovf"}, 32'(out_ovf), 32'(eO));
    check({tag, " unf"}, 32'(out_unf), 32'(eU));
    check({tag, " inexact"}, 32'(out_inexact), 32'(eI));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, " held out_f"}, 32'(out_f), 32'(eF));
      check({tag, " held in_ready"}, 32'(in_ready), 32'd0);
      check({tag, " held out_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] mf;
    logic mo, mu, mi, sawValid;
    logic [21:0] rsig;
    logic [5:0] rfl;
    int rex, sel;

    tbl[0]  = '{1'b0,   0, 22'h100000, NRM, 16'h3C00, 1'b0, 1'b0, 1'b0,  3};
    tbl[1]  = '{1'b0,   0, 22'h240000, NRM, 16'h4080, 1'b0, 1'b0, 1'b0,  4};
    tbl[2]  = '{1'b0,   0, 22'h1FFFFF, NRM, 16'h4000, 1'b0, 1'b0, 1'b1,  3};
    tbl[3]  = '{1'b0,  16, 22'h100000, NRM, 16'h7C00, 1'b1, 1'b0, 1'b1,  3};
    tbl[4]  = '{1'b0, -24, 22'h100000, NRM, 16'h0001, 1'b0, 1'b0, 1'b0, 13};
    tbl[5]  = '{1'b0, -25, 22'h100000, NRM, 16'h0000, 1'b0, 1'b1, 1'b1, 14};
    tbl[6]  = '{1'b1,   0, 22'h000000, QN,  16'hFE00, 1'b0, 1'b0, 1'b0,  1};
    tbl[7]  = '{1'b1,   0, 22'h100000, ZR,  16'h8000, 1'b0, 1'b0, 1'b0,  1};
    tbl[8]  = '{1'b0,   3, 22'h000000, NRM, 16'h0000, 1'b0, 1'b0, 1'b0,  1};
    tbl[9]  = '{1'b0,   0, 22'h100000, INF, 16'h7C00, 1'b0, 1'b0, 1'b0,  1};
    tbl[10] = '{1'b0,   0, 22'h000000, SN,  16'h7E00, 1'b0, 1'b0, 1'b0,  1};
    tbl[11] = '{1'b0,   0, 22'h080000, NRM, 16'h3800, 1'b0, 1'b0, 1'b0,  4};
    tbl[12] = '{1'b0, -14, 22'h080000, NRM, 16'h0200, 1'b0, 1'b0, 1'b0,  3};
    tbl[13] = '{1'b0,  15, 22'h3FFFFF, NRM, 16'h7C00, 1'b1, 1'b0, 1'b1,  4};
    tbl[14] = '{1'b0,  15, 22'h1FFC00, NRM, 16'h7BFF, 1'b0, 1'b0, 1'b0,  3};
    tbl[15] = '{1'b0, -15, 22'h1FFFFF, NRM, 16'h0400, 1'b0, 1'b0, 1'b1,  4};
    tbl[16] = '{1'b1,   1, 22'h180000, NRM, 16'hC200, 1'b0, 1'b0, 1'b0,  3};

    #2;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_f", 32'(out_f), 32'd0);
    check("reset flags", 32'({out_ovf, out_unf, out_inexact}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 17; v++)
      runOp($sformatf("tbl%0d", v), tbl[v].sg, tbl[v].ex, tbl[v].sig, tbl[v].fl,
            tbl[v].f, tbl[v].o, tbl[v].u, tbl[v].i, tbl[v].lat, 0);

    runOp("qnan hold", 1'b1, 0, 22'h0, QN, 16'hFE00, 1'b0, 1'b0, 1'b0, 1, 3);

    // Abort a subnormal-producing operand while it is still left-shifting.
    in_sign = 1'b0; in_exp = -8'sd5; in_sig = 22'h000001; in_flags = NRM; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #3;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    check("midreset no output", 32'(sawValid), 32'd0);
    runOp("after reset", 1'b0, 0, 22'h100000, NRM, 16'h3C00, 1'b0, 1'b0, 1'b0, 3, 0);

    for (int r = 0; r < 200; r++) begin
      rex  = int'($urandom_range(0, 60)) - 40;
      rsig = 22'($urandom) & 22'((32'd1 << $urandom_range(1, 22)) - 1);
      sel  = int'($urandom_range(0, 15));
      rfl  = NRM;
      if (sel == 0) rsig = '0;
      else if (sel == 1) rfl = QN;
      else if (sel == 2) rfl = INF;
      else if (sel == 3) rfl = ZR;
      model(1'($urandom), rex, rsig, rfl, mf, mo, mu, mi);
      runOp($sformatf("rnd%0d", r), mf[15], rex, rsig, rfl, mf, mo, mu, mi, -1,
            int'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErr);
    $finish;
  end

endmodule

// File: doc/fp_pack.md
# fp_pack

Packs an unpacked floating-point value (sign, signed unbiased exponent, wide unnormalized significand, class flags) into an IEEE-754 binary encoding with round-to-nearest-even. It is the inverse of the classify/unpack stage and sits at the output of each arithmetic datapath. The multiplier feeds it the raw double-width product directly. Normalization and denormalization are iterative, one bit per cycle, behind a valid/ready handshake.

## Interface
- NEXP, 5, exponent field width
- NSIG, 10, stored fraction width; internal significand width W = 2*NSIG+2
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input operand valid
- in_ready  out  1  block can accept; high only in IDLE
- in_sign  in  1  sign
- in_exp  in  NEXP+3 signed  unbiased exponent
- in_sig  in  W  significand; bits [W-1:W-2] integer, binary point below bit 2*NSIG
- in_flags  in  LAST_FLAG  class flags (SNAN, QNAN, INFINITY, ZERO, SUBNORMAL, NORMAL)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_f  out  NEXP+NSIG+1  packed encoding
- out_ovf, out_unf, out_inexact  out  1 each  exception flags for out_f

## Operation
- Constants: BIAS = 2^(NEXP-1)-1, EMIN = 1-BIAS, EMAX = BIAS. Internal exponent e is NEXP+3 signed; significand register s is W bits; sticky bit st.
- IDLE: on in_valid&in_ready, capture sign, e, s, and flags, and clear st. Then branch:
  - SNAN|QNAN: out_f = {sign, all-ones exp, 1, zeros}. Go to DONE.
  - INFINITY: out_f = {sign, all-ones exp, zeros}. Go to DONE.
  - ZERO, or in_sig==0: out_f = {sign, zeros}. Go to DONE.
  - Otherwise go to NORM.
- NORM (one action per cycle):
  - If s[W-1]: s>>=1, st|=s[0], e+=1.
  - Else if !s[2*NSIG] and e>EMIN: s<<=1, e-=1.
  - Else go to DENORM.
- DENORM (one action per cycle):
  - If e<EMIN and s!=0: s>>=1, st|=s[0], e+=1.
  - If e<EMIN and s==0: e=EMIN.
  - Else go to ROUND.
- ROUND, in one cycle:
  - keep = s[2*NSIG:NSIG], g = s[NSIG-1], t = |s[NSIG-2:0] | st.
  - Round up when g&(t|keep[0]). A carry-out of keep shifts keep right by 1 and sets e+=1.
  - If e>EMAX: out_f = signed infinity, ovf=1, inexact=1.
  - Else if keep[NSIG]=0: biased exponent 0 (subnormal or zero).
  - Else: biased exponent = e+BIAS, fraction = keep[NSIG-1:0].
  - inexact = g|t. unf = inexact & (result is subnormal or zero).
  - Go to DONE.
- DONE: out_valid=1. On out_ready go to IDLE.

## Timing
- Reset values: state IDLE, out_valid 0, in_ready 1, out_f 0, all exception flags 0.
- Reset asserted mid-operation discards the operation; no output is produced.
- Latency counts clock edges from the acceptance edge to out_valid rising:
  - Specials and zero: 1.
  - Finite values: 3 + left shifts + right shifts.
  - An already-normalized in-range input takes 3.
- out_f and the flags are registered. They are held stable while out_valid&!out_ready.
- No overlap: the next operand is accepted no earlier than the cycle after the out_valid&out_ready handshake.
- Worst case is bounded by W + (EMIN - min in_exp) + 3.

## Structure
- BIAS, EMIN, EMAX, the flag indices and LAST_FLAG live in the shared ieee-754-flags include, shared with the unpack stage.
- FSM state encoding is local to the block.
- One sub-module, fp_round_rne: combinational keep/g/t to rounded significand, carry, and inexact. It is reusable by the adder.

## Test plan
- exp 0, sig 0x100000 (1.0), NORMAL -> out_f 0x3C00, no flags, out_valid 3 cycles after accept.
- exp 0, sig 0x240000 (2.25) -> one right shift; out_f 0x4080, exact.
- exp 0, sig 0x1FFFFF -> round-up carry; out_f 0x4000, inexact=1. exp 16, sig 0x100000 -> 0x7C00, ovf=1, inexact=1.
- exp -24, sig 0x100000 -> 0x0001, exact, unf=0. exp -25, sig 0x100000 -> tie to even gives 0x0000, unf=1, inexact=1.
- sign 1, flags QNAN -> 0xFE00 after 1 cycle. Hold out_ready low 3 cycles -> out_f is stable and in_ready stays low.
- Pulse rst_n low during NORM of a subnormal-producing input -> out_valid stays 0, in_ready=1. The next operand packs correctly.
